conv_enc_frame_ctrl: RTL

- Frame-level sequencer for the rate-1/2, K=3 convolutional encoder datapath.
- Accepts a parallel frame of data bits through a valid/ready handshake, feeds the bits MSB-first into an internal encoder shift state, then appends K-1 = 2 zero tail bits to return the trellis to state 00.
- Emits one 2-bit code symbol per output handshake, with backpressure and a last-symbol flag.
- Sits between the payload source and the modulator/symbol FIFO.

---
 rtl/conv_enc_frame_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/conv_enc_frame_ctrl.sv
// conv_enc_frame_ctrl: frame sequencer for a rate-1/2 K=3 convolutional encoder with tail flush
module conv_enc_frame_ctrl #(
  parameter int         FRAME_LEN = 4,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAME_LEN-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_sym,
  output logic                 out_last,
  output logic                 busy
);
  localparam int CW = $clog2(FRAME_LEN + 2) + 1;
  typedef enum logic [1:0] {IDLE, ENCODE, FLUSH} state_t;
  state_t               state;
  logic [FRAME_LEN-1:0] frame;
  logic [FRAME_LEN-1:0] frame_nxt;
  logic                 s1, s2, b, nb;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  function automatic logic [1:0] enc(input logic [2:0] r);
    return {^(G0 & r), ^(G1 & r)};
  endfunction
  // shifting the frame left feeds zeros in behind the data, which are exactly the tail bits
  assign frame_nxt = frame << 1;
  assign b         = frame[FRAME_LEN-1];
  assign nb        = frame_nxt[FRAME_LEN-1];
  assign cnt_nxt   = cnt + CW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame     <= '0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (state == IDLE) begin
      in_ready <= 1'b1;
      if (in_valid && in_ready) begin
        state     <= ENCODE;
        frame     <= in_data;
        s1        <= 1'b0;
        s2        <= 1'b0;
        cnt       <= '0;
        in_ready  <= 1'b0;
        out_valid <= 1'b1;
        out_sym   <= enc({in_data[FRAME_LEN-1], 2'b00});
        out_last  <= 1'b0;
        busy      <= 1'b1;
      end
    end else if (out_ready) begin
      frame <= frame_nxt;
      s1    <= b;
      s2    <= s1;
      cnt   <= cnt_nxt;
      if (cnt_nxt == CW'(FRAME_LEN + 2)) begin
        state     <= IDLE;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        state    <= (cnt_nxt >= CW'(FRAME_LEN)) ? FLUSH : ENCODE;
        out_sym  <= enc({nb, b, s1});
        out_last <= cnt_nxt == CW'(FRAME_LEN + 1);
      end
    end
  end
endmodule
